// File: rtl/pad_pkg.sv
// pad_pkg: shared types and constants for the SNES pad reader.
// Holds the FSM state type, the pad word width and button bit indices.
package pad_pkg;

  localparam int PAD_BITS = 16;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_LO,
    S_CLK_HI,
    S_DONE
  } pad_state_t;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: protocol pacing divider, one tick every TICK_DIV cycles.
// Ports: clock, reset_l, clear (sync zero), en (count), tick (strobe).
module tick_gen #(
  parameter int TICK_DIV = 300
) (
  input  logic clock,
  input  logic reset_l,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snes_pad_reader.sv
// snes_pad_reader: latches an SNES pad and shifts in its 16 button bits.
// Ports: clock, reset_l, start, ctrl_data in; ctrl_latch, ctrl_clk, buttons, valid, busy out.
module snes_pad_reader
  import pad_pkg::*;
#(
  parameter int TICK_DIV = 300
) (
  input  logic                clock,
  input  logic                reset_l,
  input  logic                start,
  input  logic                ctrl_data,
  output logic                ctrl_latch,
  output logic                ctrl_clk,
  output logic [PAD_BITS-1:0] buttons,
  output logic                valid,
  output logic                busy
);

  pad_state_t state, nstate;

  logic                tick;
  logic                accept;
  logic                half;
  logic                last;
  logic [4:0]          pulse_cnt;
  logic [3:0]          next_bit;
  logic [PAD_BITS-1:0] shreg;

  assign accept   = (state == S_IDLE) && start;
  assign last     = (pulse_cnt == 5'd15);
  assign next_bit = pulse_cnt[3:0] + 4'd1;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clock   (clock),
    .reset_l (reset_l),
    .clear   (accept),
    .en      (state != S_IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) state <= S_IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate     = state;
    ctrl_latch = 1'b0;
    ctrl_clk   = 1'b1;
    busy       = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) nstate = S_LATCH;
      end
      S_LATCH: begin
        ctrl_latch = 1'b1;
        if (tick && half) nstate = S_CLK_LO;
      end
      S_CLK_LO: begin
        ctrl_clk = 1'b0;
        if (tick) nstate = S_CLK_HI;
      end
      S_CLK_HI: begin
        if (tick) nstate = last ? S_DONE : S_CLK_LO;
      end
      S_DONE: begin
        nstate = S_IDLE;
      end
      default: begin
        nstate = S_IDLE;
      end
    endcase
  end

  // half marks that the first of the two latch ticks has passed.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      half      <= 1'b0;
      pulse_cnt <= '0;
      shreg     <= '0;
    end else if (accept) begin
      half      <= 1'b0;
      pulse_cnt <= '0;
      shreg     <= '0;
    end else if (tick) begin
      unique case (1'b1)
        state == S_LATCH: begin
          half <= 1'b1;
          if (half) shreg[0] <= ~ctrl_data;
        end
        state == S_CLK_HI && !last: begin
          shreg[next_bit] <= ~ctrl_data;
          pulse_cnt       <= pulse_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Word and strobe are registered on entry to DONE so they appear together.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      buttons <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= (state == S_CLK_HI) && tick && last;
      if ((state == S_CLK_HI) && tick && last) buttons <= shreg;
    end
  end

endmodule

// File: doc/snes_pad_reader.md
# snes_pad_reader

Serial reader for one SNES-style game controller. On a `start` request it drives the pad's latch and clock lines and shifts in 16 active-low button bits. It then publishes the inverted 16-bit button word with a one-cycle `valid` strobe. It sits between the frame-timing logic, which pulses `start` once per frame, and the input register file that the CPU reads. Internally it uses a tick divider for protocol pacing and a pulse counter for bit indexing.

## Interface
Parameters:
- `TICK_DIV`, default 300: clock cycles per protocol half-period (6 µs at 50 MHz); legal range ≥ 2.

Ports:
- `clock` input, 1 bit: system clock.
- `reset_l` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: request one read; sampled only in IDLE.
- `ctrl_data` input, 1 bit: pad serial data, active-low, already synchronised upstream.
- `ctrl_latch` output, 1 bit: pad latch, active-high.
- `ctrl_clk` output, 1 bit: pad clock; idles high.
- `buttons` output, 16 bits: last completed read; 1 = pressed; bit k = k-th bit shifted out.
- `valid` output, 1 bit: one-cycle strobe, asserted in the cycle `buttons` first shows a new word.
- `busy` output, 1 bit: high from the cycle after `start` is accepted until the read completes.

## Operation
- States: IDLE, LATCH, CLK_LO, CLK_HI, DONE.
- IDLE:
  - All pad outputs are at idle values: `ctrl_latch`=0, `ctrl_clk`=1.
  - `start`=1 goes to LATCH, clears the tick divider and clears the pulse counter.
- Tick divider:
  - Counts 0..TICK_DIV-1 while not in IDLE.
  - Issues `tick` in the cycle the count is TICK_DIV-1, then wraps to 0.
- LATCH:
  - `ctrl_latch`=1, `ctrl_clk`=1.
  - Lasts 2 ticks.
  - On the 2nd tick: capture `~ctrl_data` into bit 0 of the shift register, then go to CLK_LO.
- CLK_LO:
  - `ctrl_clk`=0.
  - Lasts 1 tick, then goes to CLK_HI.
- CLK_HI:
  - `ctrl_clk`=1.
  - Lasts 1 tick. On that tick, with pulse counter value k (0..15):
    - if k<15: capture `~ctrl_data` into bit k+1, increment k, go to CLK_LO;
    - if k=15: go to DONE with no capture.
- DONE:
  - Lasts one cycle.
  - Transfers the shift register to `buttons`, pulses `valid`, drops `busy`, returns to IDLE.
- Bus behaviour:
  - `buttons` changes only in DONE; a partial read is never visible.
  - `start` while busy is ignored; requests are not queued.
- Pulse counter:
  - 5 bits wide; it counts exactly 16 clock pulses per read.

## Timing
- Reset values:
  - `ctrl_latch`=0, `ctrl_clk`=1, `buttons`=16'h0000, `valid`=0, `busy`=0.
  - State is IDLE; the divider and the pulse counter are 0.
- `start` accepted at edge N:
  - `busy` and `ctrl_latch` are high from cycle N+1.
  - `ctrl_latch` falls after 2·TICK_DIV cycles.
  - 16 low/high clock pulses follow, each half lasting TICK_DIV cycles.
- Busy window:
  - `busy` is high for exactly 34·TICK_DIV + 1 cycles, including the DONE cycle.
  - `valid` is high only in that final DONE cycle.
  - `start` asserted in the DONE cycle is ignored. The earliest accepted restart is the cycle after DONE.
- Reset asserted mid-read:
  - All outputs return to their reset values immediately.
  - `buttons` is cleared; no `valid` strobe is produced.
- A `start` held high continuously produces back-to-back reads separated by one IDLE cycle.

## Structure
- Shared package `pad_pkg`:
  - state enum `pad_state_t`;
  - button index constants: B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11 (bits 12-15 are pad ID bits);
  - `PAD_BITS`=16.
- Sub-module `tick_gen`:
  - parameter TICK_DIV;
  - ports `clock`, `reset_l`, `clear`, `en`, `tick`.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: `reset_l` low → `ctrl_clk`=1, `ctrl_latch`=0, `buttons`=0, `busy`=0, `valid`=0.
- Single read:
  - stimulus: `start` pulse at cycle 0; pad model presents 16'b1111_0000_0000_0001 pressed pattern (line low for pressed);
  - response: `ctrl_latch` high for cycles 1-8; exactly 16 `ctrl_clk` falling edges; `valid` only at cycle 137; `buttons`=16'hF001.
- Bit order: only A pressed → `buttons`=16'h0100; only R pressed → 16'h0800.
- Ignored start: `start` re-pulsed at cycles 20 and 137 → only one read; `busy` falls after cycle 137; the next `start` at cycle 138 begins a new latch at cycle 139.
- Reset mid-read: `reset_l` low at cycle 60 after a prior read left `buttons`=16'h00FF → `buttons`=0, `ctrl_clk`=1, no `valid`; a fresh `start` completes normally.
- Continuous `start`: reads complete at cycles 137, 275 and 413; `valid` is high exactly those three cycles.
